// File: rtl/cacheline_adaptor.sv
// Bridges one 256-bit cacheline request to four 64-bit memory beats (read or write).
// Latency: resp_o pulses the cycle after the 4th accepted beat (6 cycles minimum).
// Backpressure: resp_i=0 stalls the burst; cache requests are held until resp_o.
module cacheline_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int beats = s_line / s_burst;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [s_line-1:0] wline;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      wline     <= '0;
      line_o    <= '0;
      address_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 2'd0;
          // Write wins when both requests are raised together.
          if (write_i) begin
            state     <= WRITE;
            address_o <= {address_i[31:5], 5'b0};
            wline     <= line_i;
          end else if (read_i) begin
            state     <= READ;
            address_o <= {address_i[31:5], 5'b0};
          end
        end
        READ: begin
          if (resp_i) begin
            for (int k = 0; k < beats; k++) begin
              if (cnt == 2'(k)) line_o[k*s_burst +: s_burst] <= burst_i;
            end
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= DONE;
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    burst_o = '0;
    for (int k = 0; k < beats; k++) begin
      if (cnt == 2'(k)) burst_o = wline[k*s_burst +: s_burst];
    end
  end

  assign read_o  = (state == READ);
  assign write_o = (state == WRITE);
  assign resp_o  = (state == DONE);

endmodule
